// File: rtl/simple_splitter.sv
// Wide-to-narrow stream downsizer: each accepted wide word is emitted LSB slice first,
// one narrow beat per cycle, with an optional short final word via din_beats.
module simple_splitter #(
    parameter int  DATA_IN_WIDTH  = 128,
    parameter int  DATA_OUT_WIDTH = 16,
    localparam int RATIO          = DATA_IN_WIDTH / DATA_OUT_WIDTH,
    localparam int CNT_W          = $clog2(RATIO)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      din_vld,
    output logic                      din_rdy,
    input  logic                      din_last,
    input  logic [CNT_W-1:0]          din_beats,
    input  logic [DATA_IN_WIDTH-1:0]  din,
    output logic                      dout_vld,
    output logic                      dout_last,
    output logic [DATA_OUT_WIDTH-1:0] dout
);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e                    state_q, state_d;
    logic [DATA_IN_WIDTH-1:0]  sreg_q, sreg_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]          limit_q, limit_d;
    logic                      last_q, last_d;
    logic [DATA_OUT_WIDTH-1:0] dout_q, dout_d;
    logic                      at_limit;
    logic                      accept;

    assign at_limit = (cnt_q == limit_q);
    assign accept   = din_vld && din_rdy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (at_limit && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        din_rdy   = (state_q == IDLE) || at_limit;
        dout_vld  = (state_q == SHIFT);
        dout_last = (state_q == SHIFT) && last_q && at_limit;
        dout      = dout_q;
    end

    // Slice 0 goes straight to the output register on accept; cnt tracks the beat on dout.
    always_comb begin
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        last_d  = last_q;
        dout_d  = dout_q;
        if (accept) begin
            sreg_d  = din >> DATA_OUT_WIDTH;
            dout_d  = din[DATA_OUT_WIDTH-1:0];
            cnt_d   = '0;
            limit_d = (din_beats == '0) ? CNT_W'(RATIO - 1) : din_beats - CNT_W'(1);
            last_d  = din_last;
        end else if (state_q == SHIFT && !at_limit) begin
            sreg_d = sreg_q >> DATA_OUT_WIDTH;
            dout_d = sreg_q[DATA_OUT_WIDTH-1:0];
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            limit_q <= '0;
            last_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            last_q  <= last_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: tb/tb_simple_splitter.sv
// Bench for simple_splitter: queue-based beat model for the 128/16 instance,
// cycle table for the 32/16 instance.
module tb_simple_splitter;

    localparam int IW    = 128;
    localparam int OW    = 16;
    localparam int RATIO = 8;
    localparam int CW    = 3;
    localparam int MIW   = 32;
    localparam int MCW   = 1;

    logic clk = 1'b0;
    logic rstn;

    logic          din_vld, din_rdy, din_last;
    logic [CW-1:0] din_beats;
    logic [IW-1:0] din;
    logic          dout_vld, dout_last;
    logic [OW-1:0] dout;

    logic           m_vld, m_rdy, m_last;
    logic [MCW-1:0] m_beats;
    logic [MIW-1:0] m_din;
    logic           m_ovld, m_olast;
    logic [OW-1:0]  m_dout;

    always #5 clk = ~clk;

    simple_splitter #(.DATA_IN_WIDTH(IW), .DATA_OUT_WIDTH(OW)) u_dut (
        .clk(clk), .rstn(rstn),
        .din_vld(din_vld), .din_rdy(din_rdy), .din_last(din_last),
        .din_beats(din_beats), .din(din),
        .dout_vld(dout_vld), .dout_last(dout_last), .dout(dout)
    );

    simple_splitter #(.DATA_IN_WIDTH(MIW), .DATA_OUT_WIDTH(OW)) u_min (
        .clk(clk), .rstn(rstn),
        .din_vld(m_vld), .din_rdy(m_rdy), .din_last(m_last),
        .din_beats(m_beats), .din(m_din),
        .dout_vld(m_ovld), .dout_last(m_olast), .dout(m_dout)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned obs_vld = 0;
    int unsigned obs_last = 0;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    // Beats still owed for the current word; mq[0] is the beat on dout right now.
    beat_t         mq[$];
    logic [OW-1:0] mdout = '0;

    typedef struct {
        logic           vld;
        logic           last;
        logic [MCW-1:0] beats;
        logic [MIW-1:0] d;
        logic           rdy;
        logic           ovld;
        logic           olast;
        logic [OW-1:0]  odout;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_rdy();
        return mq.size() <= 1;
    endfunction

    task automatic model_load(input logic [IW-1:0] d, input logic l, input logic [CW-1:0] b);
        int unsigned n;
        beat_t bt;
        n = (b == '0) ? RATIO : int'(b);
        mq.delete();
        for (int unsigned i = 0; i < n; i++) begin
            bt.data = d[i*OW +: OW];
            bt.last = l && (i == n - 1);
            mq.push_back(bt);
        end
        mdout = mq[0].data;
    endtask

    function automatic logic [IW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at posedge+1: check outputs against the model, clock once, advance the model.
    task automatic cycle(output bit acc);
        logic [IW-1:0] d;
        logic          l;
        logic [CW-1:0] b;
        check("dout_vld", dout_vld, mq.size() > 0);
        check("dout_last", dout_last, (mq.size() > 0) ? mq[0].last : 1'b0);
        check("din_rdy", din_rdy, model_rdy());
        check("dout", dout, mdout);
        if (dout_vld) obs_vld++;
        if (dout_last) obs_last++;
        acc = din_vld && model_rdy();
        d = din;
        l = din_last;
        b = din_beats;
        @(posedge clk);
        #1;
        if (acc) begin
            model_load(d, l, b);
        end else if (mq.size() > 0) begin
            void'(mq.pop_front());
            if (mq.size() > 0) mdout = mq[0].data;
        end
    endtask

    task automatic idle(input int unsigned n);
        bit acc;
        din_vld = 1'b0;
        repeat (n) cycle(acc);
    endtask

    // Present a word until accepted; with noise, junk is driven while the block is busy.
    task automatic drive_word(input logic [IW-1:0] d, input logic l, input logic [CW-1:0] b,
                              input bit noise);
        bit acc = 1'b0;
        int unsigned guard = 0;
        while (!acc && guard < 32) begin
            din_vld = 1'b1;
            if (noise && !model_rdy()) begin
                din       = rand128();
                din_last  = 1'($urandom);
                din_beats = CW'($urandom);
            end else begin
                din       = d;
                din_last  = l;
                din_beats = b;
            end
            cycle(acc);
            guard++;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got no accept expected accept within 32 cycles");
        end
    endtask

    function automatic logic [IW-1:0] ramp_word(input int unsigned k);
        logic [IW-1:0] w;
        for (int unsigned i = 0; i < RATIO; i++) w[i*OW +: OW] = OW'(k * RATIO + i);
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        bit have;
        logic [IW-1:0] rd;
        logic rl;
        logic [CW-1:0] rb;

        //         vld   last  beats din            rdy   ovld  olast dout
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'hBEEF_CAFE, 1'b1, 1'b1, 1'b0, 16'hCAFE};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 16'hBEEF};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 16'hBEEF};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h1111_2222, 1'b1, 1'b1, 1'b0, 16'h2222};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h3333_4444, 1'b0, 1'b1, 1'b0, 16'h1111};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h3333_4444, 1'b1, 1'b1, 1'b1, 16'h4444};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 16'h4444};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'h5555_6666, 1'b1, 1'b1, 1'b1, 16'h6666};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h7777_8888, 1'b1, 1'b1, 1'b0, 16'h8888};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 16'h7777};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 16'h7777};

        rstn = 1'b0;
        din_vld = 1'b0; din_last = 1'b0; din_beats = '0; din = '0;
        m_vld = 1'b0; m_last = 1'b0; m_beats = '0; m_din = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout_vld", dout_vld, 1'b0);
        check("rst_dout_last", dout_last, 1'b0);
        check("rst_dout", dout, '0);
        check("rst_min_dout_vld", m_ovld, 1'b0);
        rstn = 1'b1;
        check("rst_din_rdy", din_rdy, 1'b1);

        for (int i = 0; i < 11; i++) begin
            m_vld = tbl[i].vld; m_last = tbl[i].last; m_beats = tbl[i].beats; m_din = tbl[i].d;
            check($sformatf("min_rdy[%0d]", i), m_rdy, tbl[i].rdy);
            @(posedge clk);
            #1;
            check($sformatf("min_vld[%0d]", i), m_ovld, tbl[i].ovld);
            check($sformatf("min_last[%0d]", i), m_olast, tbl[i].olast);
            check($sformatf("min_dout[%0d]", i), m_dout, tbl[i].odout);
        end
        m_vld = 1'b0;

        obs_vld = 0;
        obs_last = 0;
        for (int unsigned k = 0; k < 3; k++) drive_word(ramp_word(k), k == 2, '0, 1'b0);
        idle(30);
        check("fullrate_beats", obs_vld, 24);
        check("fullrate_lasts", obs_last, 1);

        drive_word(rand128(), 1'b1, 3'd3, 1'b0);
        idle(6);

        for (int unsigned k = 0; k < 3; k++) begin
            drive_word(ramp_word(k + 5), 1'b1, '0, 1'b0);
            idle(7 + 5);
        end

        drive_word(ramp_word(9), 1'b0, '0, 1'b0);
        drive_word(ramp_word(10), 1'b1, 3'd5, 1'b1);
        idle(10);

        drive_word(ramp_word(11), 1'b1, '0, 1'b0);
        din_vld = 1'b0;
        repeat (4) cycle(acc);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_dout_vld", dout_vld, 1'b0);
        check("midrst_dout", dout, '0);
        check("midrst_dout_last", dout_last, 1'b0);
        mq.delete();
        mdout = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        idle(12);

        have = 1'b0;
        rd = '0; rl = 1'b0; rb = '0;
        for (int i = 0; i < 400; i++) begin
            if (!have && $urandom_range(0, 9) < 6) begin
                have = 1'b1;
                rd   = rand128();
                rl   = 1'($urandom_range(0, 1));
                rb   = CW'($urandom_range(0, 7));
            end
            din_vld   = have;
            din       = have ? rd : rand128();
            din_last  = have ? rl : 1'($urandom);
            din_beats = have ? rb : CW'($urandom);
            cycle(acc);
            if (acc) have = 1'b0;
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
